// File: rtl/omsp_sm_slot_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : omsp_sm_slot_ctrl_if                                            |
// | Purpose  : Request/response handshake bundle of the Sancus slot controller |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface omsp_sm_slot_ctrl_if #(
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 16
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [ADDR_WIDTH-1:0] req_ts;
  logic [ADDR_WIDTH-1:0] req_te;
  logic [ADDR_WIDTH-1:0] req_ds;
  logic [ADDR_WIDTH-1:0] req_de;
  logic                  rsp_valid;
  logic [1:0]            rsp_status;
  logic [ID_WIDTH-1:0]   rsp_id;

  modport master (
    output req_valid, req_op, req_ts, req_te, req_ds, req_de,
    input  req_ready, rsp_valid, rsp_status, rsp_id
  );

  modport slave (
    input  req_valid, req_op, req_ts, req_te, req_ds, req_de,
    output req_ready, rsp_valid, rsp_status, rsp_id
  );
endinterface
`default_nettype wire

// File: rtl/omsp_sm_slot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : omsp_sm_slot_ctrl                                               |
// | Purpose  : Protected-module slot table with overlap scan, ID allocation    |
// |            and current/previous module ID tracking.                        |
// | Options  : OMSP_SM_IRQ_ID_EN - report IRQ IDs as cur_id during IRQ entry  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module omsp_sm_slot_ctrl #(
  parameter int NB_SLOTS   = 8,
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int IRQ_BITS   = 4
) (
  input  logic                  mclk,
  input  logic                  puc_rst,
  omsp_sm_slot_ctrl_if.slave    bus,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  handling_irq,
  input  logic [IRQ_BITS-1:0]   irq_num,
  output logic [NB_SLOTS-1:0]   slot_enabled,
  output logic [ID_WIDTH-1:0]   cur_id,
  output logic [ID_WIDTH-1:0]   prev_id,
  output logic                  id_exhausted
);

  localparam int c_idx_w = $clog2(NB_SLOTS);

  typedef logic [c_idx_w-1:0]    idx_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ID_WIDTH-1:0]   id_t;

  localparam id_t        c_irq_id_base = {ID_WIDTH{1'b1}} << IRQ_BITS;
  localparam logic [1:0] c_st_ok       = 2'b00;
  localparam logic [1:0] c_st_overlap  = 2'b01;
  localparam logic [1:0] c_st_no_slot  = 2'b10;
  localparam logic [1:0] c_st_invalid  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_RESP} state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [1:0]          r_rsp_status;
  id_t                 r_rsp_id;
  id_t                 r_next_id;
  idx_t                r_idx;
  idx_t                r_tgt;
  addr_t               r_req_ts, r_req_te, r_req_ds, r_req_de;
  logic [NB_SLOTS-1:0] r_en;
  addr_t               r_ts [NB_SLOTS];
  addr_t               r_te [NB_SLOTS];
  addr_t               r_ds [NB_SLOTS];
  addr_t               r_de [NB_SLOTS];
  id_t                 r_sid [NB_SLOTS];
  id_t                 r_prev_cyc;
  id_t                 r_prev_id;

  id_t                 w_pc_id;
  idx_t                w_pc_idx;
  logic                w_free_any;
  idx_t                w_free_idx;
  id_t                 w_cur_id;
  logic                w_scan_ovl;
  logic                w_create_bad;
  logic                w_destroy_ok;

  // Both ranges must be non-empty to share an address.
  function automatic logic f_ovl(input addr_t a_s, input addr_t a_e,
                                 input addr_t b_s, input addr_t b_e);
    return (a_s < a_e) && (b_s < b_e) && (a_s < b_e) && (b_s < a_e);
  endfunction

  // Descending loops leave the lowest matching index as the winner.
  always_comb begin
    w_pc_id  = '0;
    w_pc_idx = '0;
    for (int i = NB_SLOTS - 1; i >= 0; i--) begin
      if (r_en[i] && (pc >= r_ts[i]) && (pc < r_te[i])) begin
        w_pc_id  = r_sid[i];
        w_pc_idx = idx_t'(i);
      end
    end
  end

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NB_SLOTS - 1; i >= 0; i--) begin
      if (!r_en[i]) begin
        w_free_any = 1'b1;
        w_free_idx = idx_t'(i);
      end
    end
  end

`ifdef OMSP_SM_IRQ_ID_EN
  assign w_cur_id = handling_irq ? (c_irq_id_base + id_t'(irq_num)) : w_pc_id;
`else
  logic w_unused_irq;
  assign w_unused_irq = handling_irq ^ (^irq_num);
  assign w_cur_id     = w_pc_id;
`endif

  assign w_scan_ovl = r_en[r_idx] &&
                      (f_ovl(r_req_ts, r_req_te, r_ts[r_idx], r_te[r_idx]) ||
                       f_ovl(r_req_ts, r_req_te, r_ds[r_idx], r_de[r_idx]) ||
                       f_ovl(r_req_ds, r_req_de, r_ts[r_idx], r_te[r_idx]) ||
                       f_ovl(r_req_ds, r_req_de, r_ds[r_idx], r_de[r_idx]));

  assign w_create_bad = (bus.req_ts >= bus.req_te) || (bus.req_ds > bus.req_de) || id_exhausted;
  assign w_destroy_ok = (w_cur_id != '0) && (w_cur_id < c_irq_id_base);

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= c_st_ok;
      r_rsp_id     <= '0;
      r_next_id    <= id_t'(1);
      r_idx        <= '0;
      r_tgt        <= '0;
      r_req_ts     <= '0;
      r_req_te     <= '0;
      r_req_ds     <= '0;
      r_req_de     <= '0;
      r_en         <= '0;
      for (int i = 0; i < NB_SLOTS; i++) begin
        r_ts[i]  <= '0;
        r_te[i]  <= '0;
        r_ds[i]  <= '0;
        r_de[i]  <= '0;
        r_sid[i] <= '0;
      end
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_req_ts    <= bus.req_ts;
            r_req_te    <= bus.req_te;
            r_req_ds    <= bus.req_ds;
            r_req_de    <= bus.req_de;
            if (bus.req_op) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              if (w_destroy_ok) begin
                // Clearing here makes cur_id drop in the response cycle.
                r_en[w_pc_idx]  <= 1'b0;
                r_sid[w_pc_idx] <= '0;
                r_rsp_status    <= c_st_ok;
                r_rsp_id        <= w_cur_id;
              end else begin
                r_rsp_status <= c_st_invalid;
                r_rsp_id     <= '0;
              end
            end else if (w_create_bad || !w_free_any) begin
              r_state      <= S_RESP;
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= w_create_bad ? c_st_invalid : c_st_no_slot;
              r_rsp_id     <= '0;
            end else begin
              r_state <= S_CHECK;
              r_idx   <= '0;
              r_tgt   <= w_free_idx;
            end
          end
        end
        S_CHECK: begin
          if (w_scan_ovl) begin
            r_state      <= S_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= c_st_overlap;
            r_rsp_id     <= '0;
          end else if (r_idx == idx_t'(NB_SLOTS - 1)) begin
            r_state <= S_COMMIT;
          end else begin
            r_idx <= r_idx + idx_t'(1);
          end
        end
        S_COMMIT: begin
          r_ts[r_tgt]  <= r_req_ts;
          r_te[r_tgt]  <= r_req_te;
          r_ds[r_tgt]  <= r_req_ds;
          r_de[r_tgt]  <= r_req_de;
          r_sid[r_tgt] <= r_next_id;
          r_en[r_tgt]  <= 1'b1;
          r_next_id    <= r_next_id + id_t'(1);
          r_state      <= S_RESP;
          r_rsp_valid  <= 1'b1;
          r_rsp_status <= c_st_ok;
          r_rsp_id     <= r_next_id;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // prev_id lags by one sample so it holds the ID that was left behind.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_prev_cyc <= '0;
      r_prev_id  <= '0;
    end else begin
      r_prev_cyc <= w_cur_id;
      if (r_prev_cyc != w_cur_id) begin
        r_prev_id <= r_prev_cyc;
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_rsp_status;
  assign bus.rsp_id     = r_rsp_id;
  assign slot_enabled   = r_en;
  assign cur_id         = w_cur_id;
  assign prev_id        = r_prev_id;
  assign id_exhausted   = (r_next_id == c_irq_id_base);

endmodule
`default_nettype wire

// File: tb/tb_omsp_sm_slot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_omsp_sm_slot_ctrl                                            |
// | Purpose  : Scoreboard bench for omsp_sm_slot_ctrl against a slot-table model|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_omsp_sm_slot_ctrl;
  localparam int NB   = 4;
  localparam int IDW  = 8;
  localparam int AW   = 16;
  localparam int IB   = 4;
  localparam int BASE = (1 << IDW) - (1 << IB);
  localparam int ST_OK = 0, ST_OVL = 1, ST_NOSLOT = 2, ST_INV = 3;

  logic          mclk;
  logic          puc_rst;
  logic [AW-1:0] pc;
  logic          handling_irq;
  logic [IB-1:0] irq_num;
  logic [NB-1:0] slot_enabled;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] prev_id;
  logic          id_exhausted;

  omsp_sm_slot_ctrl_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW)) bus ();

  omsp_sm_slot_ctrl #(
    .NB_SLOTS(NB), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .IRQ_BITS(IB)
  ) dut (
    .mclk         (mclk),
    .puc_rst      (puc_rst),
    .bus          (bus),
    .pc           (pc),
    .handling_irq (handling_irq),
    .irq_num      (irq_num),
    .slot_enabled (slot_enabled),
    .cur_id       (cur_id),
    .prev_id      (prev_id),
    .id_exhausted (id_exhausted)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // Reference slot table
  bit m_en [NB];
  int m_ts [NB], m_te [NB], m_ds [NB], m_de [NB], m_id [NB];
  int m_next_id;

  typedef struct {
    int status; int id; int due; int upd; int slot;
    int ts; int te; int ds; int de; bit chk_prev;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int checks = 0, failures = 0;
  int prev_due = -1, prev_exp = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event at cycle %0d", name, cyc);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_en[i] = 1'b0; m_ts[i] = 0; m_te[i] = 0; m_ds[i] = 0; m_de[i] = 0; m_id[i] = 0;
    end
    m_next_id = 1;
  endfunction

  // Two half-open ranges share an address iff both are non-empty and max(start) < min(end).
  function automatic bit ovl(int a0, int a1, int b0, int b1);
    int lo, hi;
    lo = (a0 > b0) ? a0 : b0;
    hi = (a1 < b1) ? a1 : b1;
    return (a0 < a1) && (b0 < b1) && (lo < hi);
  endfunction

  function automatic int model_cur_id();
`ifdef OMSP_SM_IRQ_ID_EN
    if (handling_irq) return BASE + int'(irq_num);
`endif
    for (int i = 0; i < NB; i++)
      if (m_en[i] && int'(pc) >= m_ts[i] && int'(pc) < m_te[i]) return m_id[i];
    return 0;
  endfunction

  function automatic int model_en_vec();
    int v = 0;
    for (int i = 0; i < NB; i++) if (m_en[i]) v |= (1 << i);
    return v;
  endfunction

  // Monitor: pops the scoreboard on every response and tracks visible state each cycle.
  always @(negedge mclk) begin
    if (!puc_rst) begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          fail("unexpected_rsp");
        end else begin
          mon_e = q.pop_front();
          chk("rsp_status", int'(bus.rsp_status), mon_e.status);
          chk("rsp_id", int'(bus.rsp_id), mon_e.id);
          chk("rsp_latency", cyc, mon_e.due);
          chk("req_ready_in_resp", int'(bus.req_ready), 0);
          if (mon_e.upd == 1) begin
            m_en[mon_e.slot] = 1'b1;
            m_ts[mon_e.slot] = mon_e.ts; m_te[mon_e.slot] = mon_e.te;
            m_ds[mon_e.slot] = mon_e.ds; m_de[mon_e.slot] = mon_e.de;
            m_id[mon_e.slot] = mon_e.id;
            m_next_id++;
          end else if (mon_e.upd == 2) begin
            m_en[mon_e.slot] = 1'b0;
            m_id[mon_e.slot] = 0;
          end
          if (mon_e.chk_prev) begin
            prev_due = cyc + 1;
            prev_exp = mon_e.id;
          end
        end
      end
      if (cyc == prev_due) chk("prev_id", int'(prev_id), prev_exp);
      chk("cur_id", int'(cur_id), model_cur_id());
      chk("slot_enabled", int'(slot_enabled), model_en_vec());
      chk("id_exhausted", int'(id_exhausted), int'(m_next_id == BASE));
    end
  end

  task automatic send(input int op, input int ts, input int te, input int ds, input int de,
                      input bit chk_prev);
    exp_t e;
    int n, lat, k, fr;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge mclk); #1;
      n++;
    end
    if (!bus.req_ready) fail("req_ready_wait");
    e = '{default: 0};
    e.ts = ts; e.te = te; e.ds = ds; e.de = de; e.chk_prev = chk_prev;
    lat = 1;
    if (op == 0) begin
      fr = -1;
      for (int i = NB - 1; i >= 0; i--) if (!m_en[i]) fr = i;
      if (ts >= te || ds > de || m_next_id == BASE) e.status = ST_INV;
      else if (fr < 0) e.status = ST_NOSLOT;
      else begin
        k = -1;
        for (int i = 0; i < NB && k < 0; i++)
          if (m_en[i] && (ovl(ts, te, m_ts[i], m_te[i]) || ovl(ts, te, m_ds[i], m_de[i]) ||
                          ovl(ds, de, m_ts[i], m_te[i]) || ovl(ds, de, m_ds[i], m_de[i])))
            k = i;
        if (k >= 0) begin
          e.status = ST_OVL; lat = k + 2;
        end else begin
          e.status = ST_OK; e.id = m_next_id; e.upd = 1; e.slot = fr; lat = NB + 2;
        end
      end
    end else begin
      k = model_cur_id();
      if (k != 0 && k < BASE) begin
        e.status = ST_OK; e.id = k; e.upd = 2;
        for (int i = 0; i < NB; i++) if (m_en[i] && m_id[i] == k) e.slot = i;
      end else begin
        e.status = ST_INV;
      end
    end
    e.due = cyc + lat;
    bus.req_valid = 1'b1;
    bus.req_op    = op[0];
    bus.req_ts    = AW'(ts);
    bus.req_te    = AW'(te);
    bus.req_ds    = AW'(ds);
    bus.req_de    = AW'(de);
    q.push_back(e);
    @(posedge mclk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < NB + 8) begin
      @(posedge mclk); #1;
      n++;
    end
    if (q.size() != 0) begin
      fail("rsp_wait");
      q.delete();
    end
  endtask

  task automatic issue(input int op, input int ts, input int te, input int ds, input int de,
                       input bit chk_prev);
    send(op, ts, te, ds, de, chk_prev);
    wait_done();
  endtask

  task automatic destroy_all();
    handling_irq = 1'b0;
    for (int s = 0; s < NB; s++) begin
      if (m_en[s]) begin
        pc = AW'(m_ts[s]);
        issue(1, 0, 0, 0, 0, 1'b0);
      end
    end
    pc = '0;
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
    chk({tag, "_rsp_status"}, int'(bus.rsp_status), 0);
    chk({tag, "_rsp_id"}, int'(bus.rsp_id), 0);
    chk({tag, "_slot_enabled"}, int'(slot_enabled), 0);
    chk({tag, "_cur_id"}, int'(cur_id), 0);
    chk({tag, "_prev_id"}, int'(prev_id), 0);
    chk({tag, "_id_exhausted"}, int'(id_exhausted), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts, te, ds, de, s;
    puc_rst = 1'b1;
    pc = '0; handling_irq = 1'b0; irq_num = '0;
    bus.req_valid = 1'b0; bus.req_op = 1'b0;
    bus.req_ts = '0; bus.req_te = '0; bus.req_ds = '0; bus.req_de = '0;
    model_reset();
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check_reset("rst");
    @(posedge mclk); #1;
    puc_rst = 1'b0;
    @(negedge mclk);
    check_reset("post_rst");

    // Directed walk through the main create/destroy cases
    issue(0, 'h8000, 'h8100, 'h0200, 'h0240, 1'b0);
    chk("first_slot_enabled", int'(slot_enabled), 1);
    issue(0, 'h80F0, 'h8200, 'h0300, 'h0310, 1'b0);
    issue(0, 'h9000, 'h9100, 'h0400, 'h0440, 1'b0);
    issue(0, 'hA000, 'hA100, 'h0500, 'h0540, 1'b0);
    issue(0, 'hB000, 'hB100, 'h0600, 'h0640, 1'b0);
    issue(0, 'hC000, 'hC100, 'h0700, 'h0740, 1'b0);
    issue(0, 'hD000, 'hD000, 'h0800, 'h0810, 1'b0);
    pc = 'h8010;
    @(negedge mclk);
    chk("pc_cur_id", int'(cur_id), 1);
    issue(1, 0, 0, 0, 0, 1'b1);
    @(posedge mclk); #1;
    pc = '0;
    issue(1, 0, 0, 0, 0, 1'b0);
    issue(0, 'hD000, 'hD100, 'h0900, 'h0800, 1'b0);

    handling_irq = 1'b1; irq_num = 4'd3; pc = 'h9010;
    @(negedge mclk);
`ifdef OMSP_SM_IRQ_ID_EN
    chk("irq_cur_id", int'(cur_id), BASE + 3);
`else
    chk("irq_cur_id", int'(cur_id), 2);
`endif
    @(posedge mclk); #1;
    handling_irq = 1'b0; pc = '0;

    // Randomised mix of creates and destroys over a small address space
    for (int it = 0; it < 150; it++) begin
      handling_irq = ($urandom_range(0, 7) == 0);
      irq_num = IB'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        ts = $urandom_range(0, 255);
        te = ts + $urandom_range(0, 40);
        ds = $urandom_range(200, 500);
        de = ds + $urandom_range(0, 40);
        if ($urandom_range(0, 9) == 0) de = ds - 1;
        issue(0, ts, te, ds, de, 1'b0);
      end else begin
        s = $urandom_range(0, NB - 1);
        if (m_en[s] && $urandom_range(0, 1) == 1) pc = AW'(m_ts[s]);
        else pc = AW'($urandom_range(0, 700));
        issue(1, 0, 0, 0, 0, 1'b0);
      end
    end

    // Reset in the middle of an overlap scan
    destroy_all();
    send(0, 'h6000, 'h6100, 'h7000, 'h7100, 1'b0);
    @(posedge mclk); #1;
    puc_rst = 1'b1;
    q.delete();
    model_reset();
    prev_due = -1;
    @(negedge mclk);
    check_reset("midscan_rst");
    @(posedge mclk); #1;
    puc_rst = 1'b0;
    @(negedge mclk);
    check_reset("midscan_post");
    pc = 'h6010;
    issue(0, 'h6000, 'h6100, 'h7000, 'h7100, 1'b0);
    chk("after_rst_cur_id", int'(cur_id), 1);

    // Run the ID counter up to the reserved range
    destroy_all();
    while (m_next_id < BASE) begin
      pc = '0;
      issue(0, 'h4000, 'h4010, 'h5000, 'h5010, 1'b0);
      pc = 'h4000;
      issue(1, 0, 0, 0, 0, 1'b0);
    end
    pc = '0;
    issue(0, 'h4000, 'h4010, 'h5000, 'h5010, 1'b0);
    chk("exhausted_flag", int'(id_exhausted), 1);

    repeat (3) @(posedge mclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
